// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring-code monitor.
// Helpers work on a MAX_N-wide vector so any ring width up to MAX_N can use them.
package ring_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } ring_state_e;

  // Right rotate within an n-bit ring; bits at or above n must be zero.
  function automatic logic [MAX_N-1:0] ring_next(input logic [MAX_N-1:0] code, input int n);
    logic [MAX_N-1:0] lsb;
    lsb = {{(MAX_N-1){1'b0}}, code[0]};
    return (code >> 1) | (lsb << (n - 1));
  endfunction

  function automatic logic onehot_chk(input logic [MAX_N-1:0] code);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (code[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
// The binary output is only meaningful while is_onehot_o is high.
module onehot_to_bin
  import ring_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  code_i,
  output logic [IW-1:0] bin_o,
  output logic          is_onehot_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < N; i++) begin
      if (code_i[i]) bin_o = bin_o | IW'(i);
    end
    is_onehot_o = onehot_chk(MAX_N'(code_i));
  end

endmodule

// File: rtl/ring_code_monitor.sv
// Receive-side checker for a right-rotating one-hot ring code: decodes the index,
// tracks lock, flags one-hot and sequence errors and keeps a saturating error count.
module ring_code_monitor
  import ring_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(N),
  localparam int GW      = $clog2(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             locked,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  ring_state_e      state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [GW-1:0]    good_q, good_d;
  logic [IW-1:0]    index_q, index_d;
  logic             iv_q, iv_d;
  logic             locked_q, locked_d;
  logic             oe_q, oe_d;
  logic             se_q, se_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] errc_q, errc_d;

  logic [IW-1:0]    bin;
  logic             is_oh;
  logic [N-1:0]     exp_code;
  logic             match;
  logic             err_inc;

  onehot_to_bin #(.N(N), .IW(IW)) u_enc (
    .code_i      (code_in),
    .bin_o       (bin),
    .is_onehot_o (is_oh)
  );

  assign exp_code = N'(ring_next(MAX_N'(prev_q), N));
  assign match    = (code_in == exp_code);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    index_d = index_q;
    iv_d    = iv_q;
    oe_d    = 1'b0;
    se_d    = 1'b0;
    wrap_d  = 1'b0;
    err_inc = 1'b0;
    if (code_valid) begin
      if (!is_oh) begin
        // Index holds its last good value; only the valid flag drops.
        oe_d    = 1'b1;
        err_inc = 1'b1;
        iv_d    = 1'b0;
        state_d = SEARCH;
        good_d  = '0;
      end else begin
        prev_d  = code_in;
        index_d = bin;
        iv_d    = 1'b1;
        case (state_q)
          SEARCH: begin
            good_d  = '0;
            state_d = SYNC;
          end
          SYNC: begin
            if (match) begin
              if (good_q == GW'(LOCK_CNT - 1)) begin
                state_d = LOCKED;
                good_d  = '0;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else begin
              // Re-phase on the new code rather than dropping to SEARCH.
              se_d    = 1'b1;
              err_inc = 1'b1;
              good_d  = '0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_d = (code_in == N'(1)) && (prev_q == N'(2));
            end else begin
              se_d    = 1'b1;
              err_inc = 1'b1;
              state_d = SYNC;
              good_d  = '0;
            end
          end
          default: begin
            state_d = SEARCH;
            good_d  = '0;
          end
        endcase
      end
    end
    errc_d   = (err_inc && (errc_q != '1)) ? errc_q + 1'b1 : errc_q;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      good_q   <= '0;
      index_q  <= '0;
      iv_q     <= 1'b0;
      locked_q <= 1'b0;
      oe_q     <= 1'b0;
      se_q     <= 1'b0;
      wrap_q   <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      index_q  <= index_d;
      iv_q     <= iv_d;
      locked_q <= locked_d;
      oe_q     <= oe_d;
      se_q     <= se_d;
      wrap_q   <= wrap_d;
      errc_q   <= errc_d;
    end
  end

  assign index       = index_q;
  assign index_valid = iv_q;
  assign locked      = locked_q;
  assign onehot_err  = oe_q;
  assign seq_err     = se_q;
  assign wrap        = wrap_q;
  assign err_count   = errc_q;

endmodule
